// File: rtl/dcache_refill_ctrl.sv
// Miss/refill and write-through sequencer for a 2-way, 8-set, 4-word-block data cache.
// Load misses fetch the whole block in word order 0..3; every store is written through and stalls until acked.
module dcache_refill_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 25,
  parameter int SET_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_stall,
  input  logic                  cache_hit,
  input  logic                  cache_victim,
  output logic                  fill_en,
  output logic                  fill_commit,
  output logic                  fill_way,
  output logic [SET_WIDTH-1:0]  fill_set,
  output logic [1:0]            fill_word,
  output logic [TAG_WIDTH-1:0]  fill_tag,
  output logic [DATA_WIDTH-1:0] fill_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] COMMIT = 2'd2;
  localparam logic [1:0] WRITE  = 2'd3;

  logic [1:0]           state;
  logic [1:0]           cnt;
  logic [TAG_WIDTH-1:0] lat_tag;
  logic [SET_WIDTH-1:0] lat_set;
  logic                 lat_way;
  logic                 ack_seen;
  logic                 unused_ok;

  // An ack only counts while a request is actually outstanding.
  assign ack_seen  = mem_req & mem_ack;
  assign unused_ok = &{1'b0, cpu_addr[1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      lat_tag   <= '0;
      lat_set   <= '0;
      lat_way   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && cpu_we) begin
            state     <= WRITE;
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= {cpu_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= cpu_wdata;
          end else if (cpu_req && !cache_hit) begin
            state    <= REFILL;
            cnt      <= 2'd0;
            lat_tag  <= cpu_addr[ADDR_WIDTH-1 -: TAG_WIDTH];
            lat_set  <= cpu_addr[4 +: SET_WIDTH];
            lat_way  <= cache_victim;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= {cpu_addr[ADDR_WIDTH-1:4], 4'b0000};
          end
        end
        REFILL: begin
          if (ack_seen) begin
            cnt      <= cnt + 2'd1;
            mem_addr <= {lat_tag, lat_set, cnt + 2'd1, 2'b00};
            if (cnt == 2'd3) begin
              state   <= COMMIT;
              mem_req <= 1'b0;
            end
          end
        end
        COMMIT: state <= IDLE;
        WRITE: begin
          if (ack_seen) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes and stall are forced low while reset is asserted so a half-done refill cannot commit.
  always_comb begin
    cpu_stall   = 1'b0;
    fill_en     = 1'b0;
    fill_commit = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE:   cpu_stall = cpu_req & (cpu_we | ~cache_hit);
        REFILL: begin
          cpu_stall = 1'b1;
          fill_en   = ack_seen;
        end
        COMMIT: begin
          cpu_stall   = 1'b1;
          fill_commit = 1'b1;
        end
        WRITE:  cpu_stall = ~ack_seen;
        default: cpu_stall = 1'b0;
      endcase
    end
  end

  assign fill_way  = lat_way;
  assign fill_set  = lat_set;
  assign fill_tag  = lat_tag;
  assign fill_word = cnt;
  assign fill_data = mem_rdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Self-checking bench for dcache_refill_ctrl: transactions are expanded into per-cycle
// input/expected-output records, then one process drives and compares every cycle.
module tb_dcache_refill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall;
  logic        cache_hit = 1'b0, cache_victim = 1'b0;
  logic        fill_en, fill_commit, fill_way;
  logic [2:0]  fill_set;
  logic [1:0]  fill_word;
  logic [24:0] fill_tag;
  logic [31:0] fill_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [1:0]  dbg_state;

  dcache_refill_ctrl dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_stall(cpu_stall), .cache_hit(cache_hit),
    .cache_victim(cache_victim), .fill_en(fill_en), .fill_commit(fill_commit),
    .fill_way(fill_way), .fill_set(fill_set), .fill_word(fill_word), .fill_tag(fill_tag),
    .fill_data(fill_data), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // One record per clock cycle: what to drive, and what the outputs must be.
  typedef struct {
    logic        rst_n, req, we, hit, victim, ack;
    logic [31:0] addr, wdata, rdata;
    logic        e_stall, e_fill, e_commit;
    logic        chk_req, e_req;
    logic        chk_mem, e_we;
    logic [31:0] e_addr;
    logic        chk_wd;
    logic [31:0] e_wdata;
    logic        chk_fill, e_way;
    logic [2:0]  e_set;
    logic [24:0] e_tag;
    logic        chk_word;
    logic [1:0]  e_word;
    logic [31:0] e_data;
    logic        chk_idle;
  } cyc_t;

  cyc_t        cq[$];
  logic [31:0] exp_q[$];
  logic [31:0] fill_log[$];
  int tests = 0, fails = 0;
  int seg_fill, seg_commit, seg_stall, seg_req;
  logic [31:0] last_ack_addr, last_ack_wdata;
  logic        last_ack_we, last_fill_way;
  logic [2:0]  last_fill_set;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic cyc_t blank();
    cyc_t c;
    c = '{default: '0};
    c.rst_n   = 1'b1;
    c.chk_req = 1'b1;
    c.rdata   = $urandom;
    return c;
  endfunction

  // Driver tasks: expand CPU/memory transactions into cycle records
  task automatic push_idle(input logic spur);
    cyc_t c;
    c = blank();
    c.ack = spur;
    c.hit = 1'($urandom_range(0, 1));
    cq.push_back(c);
  endtask

  task automatic push_hit();
    cyc_t c;
    c = blank();
    c.req = 1'b1;
    c.addr = $urandom;
    c.hit = 1'b1;
    c.victim = 1'($urandom_range(0, 1));
    cq.push_back(c);
  endtask

  task automatic push_reset(input int n, input logic post_check);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c = blank();
      c.rst_n = 1'b0;
      c.chk_req = 1'b0;
      c.req = 1'($urandom_range(0, 1));
      c.ack = 1'($urandom_range(0, 1));
      cq.push_back(c);
    end
    if (post_check) begin
      c = blank();
      c.chk_mem = 1'b1;
      c.chk_wd = 1'b1;
      c.chk_idle = 1'b1;
      cq.push_back(c);
    end
  endtask

  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input int gap);
    cyc_t c;
    c = blank();
    c.req = 1'b1; c.we = 1'b1; c.addr = a; c.wdata = d;
    c.hit = 1'($urandom_range(0, 1));
    c.e_stall = 1'b1;
    cq.push_back(c);
    for (int i = 0; i <= gap; i++) begin
      c = blank();
      c.req = 1'b1; c.we = 1'b1; c.addr = a; c.wdata = d;
      c.hit = 1'($urandom_range(0, 1));
      c.ack = (i == gap);
      c.e_stall = (i != gap);
      c.e_req = 1'b1;
      c.chk_mem = 1'b1; c.e_we = 1'b1; c.e_addr = {a[31:2], 2'b00};
      c.chk_wd = 1'b1; c.e_wdata = d;
      cq.push_back(c);
    end
  endtask

  // Load miss: one IDLE stall cycle, words 0..3 each after gap[k] idle cycles, commit, then a hit.
  task automatic push_miss(input logic [31:0] a, input logic v, input int g0, input int g1,
                           input int g2, input int g3, input int nacks);
    cyc_t c;
    int   g[4];
    logic [1:0] kk;
    g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
    c = blank();
    c.req = 1'b1; c.addr = a; c.victim = v;
    c.e_stall = 1'b1;
    cq.push_back(c);
    for (int k = 0; k < nacks; k++) begin
      kk = k[1:0];
      for (int i = 0; i <= g[k]; i++) begin
        c = blank();
        c.req = 1'b1; c.addr = a;
        c.hit = 1'($urandom_range(0, 1));
        c.victim = 1'($urandom_range(0, 1));
        c.ack = (i == g[k]);
        c.e_stall = 1'b1;
        c.e_req = 1'b1;
        c.chk_mem = 1'b1; c.e_we = 1'b0; c.e_addr = {a[31:4], kk, 2'b00};
        c.e_fill = c.ack;
        if (c.ack) begin
          c.chk_fill = 1'b1; c.e_way = v; c.e_set = a[6:4]; c.e_tag = a[31:7];
          c.chk_word = 1'b1; c.e_word = kk; c.e_data = c.rdata;
        end
        cq.push_back(c);
      end
    end
    if (nacks == 4) begin
      c = blank();
      c.req = 1'b1; c.addr = a;
      c.ack = 1'($urandom_range(0, 1));
      c.e_stall = 1'b1; c.e_commit = 1'b1;
      c.chk_fill = 1'b1; c.e_way = v; c.e_set = a[6:4]; c.e_tag = a[31:7];
      cq.push_back(c);
      c = blank();
      c.req = 1'b1; c.addr = a; c.hit = 1'b1;
      cq.push_back(c);
    end
  endtask

  task automatic clear_stats();
    seg_fill = 0; seg_commit = 0; seg_stall = 0; seg_req = 0;
    fill_log.delete();
  endtask

  // Compare process: drive each record after the edge, check outputs on the falling edge.
  task automatic run_q();
    cyc_t c;
    while (cq.size() > 0) begin
      c = cq.pop_front();
      @(posedge clk);
      #1;
      rst_n = c.rst_n; cpu_req = c.req; cpu_we = c.we; cpu_addr = c.addr;
      cpu_wdata = c.wdata; cache_hit = c.hit; cache_victim = c.victim;
      mem_ack = c.ack; mem_rdata = c.rdata;
      @(negedge clk);
      chk("cpu_stall", cpu_stall, c.e_stall);
      chk("fill_en", fill_en, c.e_fill);
      chk("fill_commit", fill_commit, c.e_commit);
      if (c.chk_req) chk("mem_req", mem_req, c.e_req);
      if (c.chk_mem) begin
        chk("mem_we", mem_we, c.e_we);
        chk("mem_addr", mem_addr, c.e_addr);
      end
      if (c.chk_wd) chk("mem_wdata", mem_wdata, c.e_wdata);
      if (c.chk_fill) begin
        chk("fill_way", fill_way, c.e_way);
        chk("fill_set", fill_set, c.e_set);
        chk("fill_tag", fill_tag, c.e_tag);
      end
      if (c.chk_word) begin
        chk("fill_word", fill_word, c.e_word);
        chk("fill_data", fill_data, c.e_data);
      end
      if (c.chk_idle) chk("state_idle", dbg_state, 0);
      if (fill_en) begin
        seg_fill++;
        fill_log.push_back(mem_addr);
        last_fill_set = fill_set;
        last_fill_way = fill_way;
      end
      if (fill_commit) seg_commit++;
      if (cpu_stall) seg_stall++;
      if (mem_req === 1'b1 && rst_n) seg_req++;
      if (mem_req === 1'b1 && mem_ack) begin
        last_ack_addr = mem_addr; last_ack_wdata = mem_wdata; last_ack_we = mem_we;
      end
    end
  endtask

  initial begin
    int g[4];
    int gsum;
    logic [31:0] a;

    // Reset state
    push_reset(3, 1'b1);
    run_q();

    // Directed load miss at 0x44, victim way 1, back-to-back acks
    clear_stats();
    push_miss(32'h0000_0044, 1'b1, 0, 0, 0, 0, 4);
    run_q();
    exp_q = '{32'h40, 32'h44, 32'h48, 32'h4C};
    chk("miss_fill_count", seg_fill, 4);
    for (int i = 0; i < fill_log.size() && i < 4; i++) chk("miss_addr_seq", fill_log[i], exp_q[i]);
    chk("miss_fill_set", last_fill_set, 3'd4);
    chk("miss_fill_way", last_fill_way, 1'b1);
    chk("miss_commit_count", seg_commit, 1);
    chk("miss_stall_cycles", seg_stall, 6);

    // Load hits: no stall, no memory traffic
    clear_stats();
    push_hit(); push_hit(); push_hit();
    run_q();
    chk("hit_stall_cycles", seg_stall, 0);
    chk("hit_mem_req_cycles", seg_req, 0);

    // Store 0x104 / DEADBEEF, ack after 3 waiting cycles
    clear_stats();
    push_store(32'h0000_0104, 32'hDEAD_BEEF, 3);
    push_idle(1'b0);
    run_q();
    chk("store_addr", last_ack_addr, 32'h0000_0104);
    chk("store_wdata", last_ack_wdata, 32'hDEAD_BEEF);
    chk("store_we", last_ack_we, 1'b1);
    chk("store_stall_cycles", seg_stall, 4);
    chk("store_fill_count", seg_fill + seg_commit, 0);

    // Refill with random ack gaps: mem_req high throughout, exactly 4 fills
    for (int r = 0; r < 3; r++) begin
      clear_stats();
      gsum = 0;
      for (int k = 0; k < 4; k++) begin
        g[k] = $urandom_range(0, 5);
        gsum += g[k];
      end
      push_miss($urandom, 1'($urandom_range(0, 1)), g[0], g[1], g[2], g[3], 4);
      run_q();
      chk("gap_fill_count", seg_fill, 4);
      chk("gap_req_cycles", seg_req, gsum + 4);
      chk("gap_commit_count", seg_commit, 1);
    end

    // Reset after the second refill ack: abandon, no commit, back to IDLE
    clear_stats();
    a = $urandom;
    push_miss(a, 1'b0, 1, 0, 0, 0, 2);
    push_reset(1, 1'b1);
    push_idle(1'b0); push_idle(1'b0);
    push_hit();
    run_q();
    chk("rst_mid_commit_count", seg_commit, 0);
    chk("rst_mid_fill_count", seg_fill, 2);

    // Spurious acks in IDLE are ignored
    clear_stats();
    push_idle(1'b1); push_idle(1'b1); push_idle(1'b0); push_idle(1'b1);
    push_hit();
    run_q();
    chk("spur_fill_count", seg_fill, 0);
    chk("spur_req_cycles", seg_req, 0);

    // Randomized mix of operations
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: push_hit();
        1: push_store($urandom, $urandom, $urandom_range(0, 4));
        2: push_miss($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 4);
        default: push_idle(1'($urandom_range(0, 1)));
      endcase
    end
    push_idle(1'b0);
    run_q();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
